// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - funct codes, FSM/op enums and decode helper for muldiv_sequencer
package muldiv_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;
  typedef enum logic {OP_MUL, OP_DIV} op_e;

  function automatic logic is_muldiv(input logic [5:0] f);
    return f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - EX-stage <-> mul/div sequencer signal bundle
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic [5:0]       funct_i;
  logic [WIDTH-1:0] rs_i;
  logic [WIDTH-1:0] rt_i;
  logic             hilo_rd_i;
  logic             wr_hi_i;
  logic             wr_lo_i;
  logic [WIDTH-1:0] wr_data_i;
  logic             accept_o;
  logic             busy_o;
  logic             stall_o;
  logic             done_o;
  logic             dz_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, funct_i, rs_i, rt_i, hilo_rd_i, wr_hi_i, wr_lo_i, wr_data_i,
    input  accept_o, busy_o, stall_o, done_o, dz_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, funct_i, rs_i, rt_i, hilo_rd_i, wr_hi_i, wr_lo_i, wr_data_i,
    output accept_o, busy_o, stall_o, done_o, dz_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - shared acc/shift datapath: shift-add multiply, restoring divide
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] sh_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] add_x, add_y, add_r;
  logic [WIDTH:0]   mul_t;
  logic             borrow;

  // One adder: product accumulate for MUL, trial subtract of the divisor for DIV.
  always_comb begin
    shifted = {acc_q, sh_q[WIDTH-1]};
    add_x   = (op_i == OP_MUL) ? {2'b00, acc_q} : {1'b0, shifted};
    add_y   = {2'b00, opnd_q};
    add_r   = (op_i == OP_MUL) ? add_x + add_y : add_x - add_y;
    borrow  = add_r[WIDTH+1];
    mul_t   = sh_q[0] ? add_r[WIDTH:0] : {1'b0, acc_q};
    if (op_i == OP_MUL) begin
      acc_d = mul_t[WIDTH:1];
      sh_d  = {mul_t[0], sh_q[WIDTH-1:1]};
    end else begin
      acc_d = borrow ? shifted[WIDTH-1:0] : add_r[WIDTH-1:0];
      sh_d  = {sh_q[WIDTH-2:0], ~borrow};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      sh_q   <= '0;
      opnd_q <= '0;
    end else if (load_i) begin
      acc_q  <= '0;
      sh_q   <= a_i;
      opnd_q <= b_i;
    end else if (step_i) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
    end
  end

  assign acc_o = acc_q;
  assign sh_o  = sh_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO and stall logic
// Optional signed MULT/DIV: define MULDIV_SIGNED_EN.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic    clock,
  input  logic    reset,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q;
  op_e              op_q, op_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, rs_q;
  logic             done_q, dz_q, dz_pend_q, dz_d;
  logic             accept;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-1:0] core_acc, core_sh;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
  logic sgn, rs_neg, rt_neg;
  logic neg_res_q, neg_rem_q;
`endif

  assign accept = bus.start_i & is_muldiv(bus.funct_i) & (state_q == IDLE);
  assign op_d   = bus.funct_i[1] ? OP_DIV : OP_MUL;
  assign dz_d   = (op_d == OP_DIV) && (bus.rt_i == '0);

  // Signed ops run on magnitudes; result signs are fixed up in FINISH.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    sgn    = ~bus.funct_i[0];
    rs_neg = sgn & bus.rs_i[WIDTH-1];
    rt_neg = sgn & bus.rt_i[WIDTH-1];
    opa    = rs_neg ? -bus.rs_i : bus.rs_i;
    opb    = rt_neg ? -bus.rt_i : bus.rt_i;
`else
    opa    = bus.rs_i;
    opb    = bus.rt_i;
`endif
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clock  (clock),
    .reset  (reset),
    .load_i (accept),
    .step_i (state_q == RUN),
    .op_i   (op_q),
    .a_i    (opa),
    .b_i    (opb),
    .acc_o  (core_acc),
    .sh_o   (core_sh)
  );

  always_comb begin
    prod = {core_acc, core_sh};
    quo  = core_sh;
    rem  = core_acc;
`ifdef MULDIV_SIGNED_EN
    if (neg_res_q) begin
      prod = -prod;
      quo  = -quo;
    end
    if (neg_rem_q) rem = -rem;
`endif
    if (dz_pend_q) begin
      res_hi = rs_q;
      res_lo = {WIDTH{1'b1}};
    end else if (op_q == OP_DIV) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      rs_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      dz_pend_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q      <= op_d;
            rs_q      <= bus.rs_i;
            cnt_q     <= CW'(WIDTH - 1);
            dz_q      <= 1'b0;
            dz_pend_q <= dz_d;
            state_q   <= dz_d ? FINISH : RUN;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= rs_neg ^ rt_neg;
            neg_rem_q <= rs_neg;
`endif
          end else begin
            if (bus.wr_hi_i) hi_q <= bus.wr_data_i;
            if (bus.wr_lo_i) lo_q <= bus.wr_data_i;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= FINISH;
        end
        FINISH: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          dz_q    <= dz_pend_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.accept_o = accept;
  assign bus.busy_o   = (state_q != IDLE);
  assign bus.stall_o  = bus.busy_o & (bus.start_i | bus.hilo_rd_i | bus.wr_hi_i | bus.wr_lo_i);
  assign bus.done_o   = done_q;
  assign bus.dz_o     = dz_q;
  assign bus.hi_o     = hi_q;
  assign bus.lo_o     = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer with directed vectors
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_sequencer #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.done_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: hi=%h lo=%h, required no done_o", bus.hi_o, bus.lo_o);
      end else begin
        e = exp_q.pop_front();
        chk("result_hi", bus.hi_o, e.hi);
        chk("result_lo", bus.lo_o, e.lo);
        chk("result_dz", bus.dz_o, e.dz);
      end
    end
  end

  task automatic wait_done(input string name, input int lat);
    int n = 0;
    int nb = 0;
    do begin
      @(negedge clock);
      n++;
      if (bus.busy_o) nb++;
    end while (!bus.done_o && n < 200);
    chk({name, "_latency"}, n, lat);
    chk({name, "_busy_cycles"}, nb, lat - 1);
    chk({name, "_busy_at_done"}, bus.busy_o, 0);
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz, input int lat, input bit mt);
    exp_t e;
    @(posedge clock); #1;
    bus.start_i = 1'b1; bus.funct_i = f; bus.rs_i = a; bus.rt_i = b;
    if (mt) begin
      bus.wr_hi_i = 1'b1; bus.wr_lo_i = 1'b1; bus.wr_data_i = 32'hDEAD_BEEF;
    end
    @(negedge clock);
    chk({name, "_accept"}, bus.accept_o, 1);
    e.hi = eh; e.lo = el; e.dz = edz;
    exp_q.push_back(e);
    @(posedge clock); #1;
    bus.start_i = 1'b0; bus.wr_hi_i = 1'b0; bus.wr_lo_i = 1'b0;
    wait_done(name, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int n;
    int stall_bad;
    bus.start_i = 1'b0; bus.funct_i = '0; bus.rs_i = '0; bus.rt_i = '0;
    bus.hilo_rd_i = 1'b0; bus.wr_hi_i = 1'b0; bus.wr_lo_i = 1'b0; bus.wr_data_i = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_hi", bus.hi_o, 0);
    chk("reset_lo", bus.lo_o, 0);
    chk("reset_flags", {bus.busy_o, bus.done_o, bus.dz_o, bus.stall_o}, 0);
    @(posedge clock); #1 reset = 1'b0;

    run_op("multu_7x6", FUNCT_MULTU, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, 34, 1'b0);
    run_op("divu_100_7", FUNCT_DIVU, 32'd100, 32'd7, 32'h2, 32'hE, 1'b0, 34, 1'b0);
    run_op("div_by_zero", FUNCT_DIV, 32'd5, 32'd0, 32'h5, 32'hFFFF_FFFF, 1'b1, 2, 1'b0);
    repeat (3) @(negedge clock);
    chk("dz_held", bus.dz_o, 1);
`ifdef MULDIV_SIGNED_EN
    run_op("mult_neg", FUNCT_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34, 1'b0);
    run_op("div_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b0);
    run_op("div_minneg", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, 1'b0);
`else
    run_op("mult_neg", FUNCT_MULT, 32'hFFFF_FFFD, 32'd5, 32'h4, 32'hFFFF_FFF1, 1'b0, 34, 1'b0);
    run_op("div_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC, 1'b0, 34, 1'b0);
    run_op("div_minneg", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 34, 1'b0);
`endif
    run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 34, 1'b0);
    run_op("divu_by_one", FUNCT_DIVU, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b0, 34, 1'b0);
    run_op("mt_with_accept", FUNCT_MULTU, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 34, 1'b1);

    // Invalid funct must be ignored entirely.
    @(posedge clock); #1;
    bus.start_i = 1'b1; bus.funct_i = 6'b100000; bus.rs_i = 32'd9; bus.rt_i = 32'd9;
    @(negedge clock);
    chk("invalid_accept", bus.accept_o, 0);
    @(posedge clock); #1 bus.start_i = 1'b0;
    @(negedge clock);
    chk("invalid_busy", bus.busy_o, 0);

    // MTHI/MTLO while idle, including both in one cycle.
    @(posedge clock); #1;
    bus.wr_hi_i = 1'b1; bus.wr_lo_i = 1'b1; bus.wr_data_i = 32'h1234_5678;
    @(posedge clock); #1;
    bus.wr_lo_i = 1'b0; bus.wr_data_i = 32'hCAFE_0001;
    @(posedge clock); #1 bus.wr_hi_i = 1'b0;
    @(negedge clock);
    chk("mt_hi", bus.hi_o, 32'hCAFE_0001);
    chk("mt_lo", bus.lo_o, 32'h1234_5678);

    // MFHI stall from RUN cycle 3, plus a new start held from cycle 20.
    @(posedge clock); #1;
    bus.start_i = 1'b1; bus.funct_i = FUNCT_MULTU; bus.rs_i = 32'd9; bus.rt_i = 32'd9;
    @(negedge clock);
    chk("stall_op_accept", bus.accept_o, 1);
    e.hi = 32'h0; e.lo = 32'd81; e.dz = 1'b0;
    exp_q.push_back(e);
    n = 0;
    stall_bad = 0;
    do begin
      @(posedge clock); #1;
      n++;
      if (n == 1) bus.start_i = 1'b0;
      if (n == 3) bus.hilo_rd_i = 1'b1;
      if (n == 20) begin
        bus.start_i = 1'b1; bus.rs_i = 32'd2; bus.rt_i = 32'd3;
      end
      @(negedge clock);
      if (!bus.done_o && n >= 3 && !bus.stall_o) stall_bad++;
    end while (!bus.done_o && n < 200);
    chk("stall_done_cycle", n, 34);
    chk("stall_held", stall_bad, 0);
    chk("stall_released", bus.stall_o, 0);
    chk("start_in_done_cycle", bus.accept_o, 1);
    e.hi = 32'h0; e.lo = 32'd6; e.dz = 1'b0;
    exp_q.push_back(e);
    @(posedge clock); #1;
    bus.start_i = 1'b0; bus.hilo_rd_i = 1'b0;
    wait_done("queued_start", 34);

    // Reset during RUN cycle 10 aborts with no done_o.
    @(posedge clock); #1;
    bus.start_i = 1'b1; bus.funct_i = FUNCT_MULTU; bus.rs_i = 32'hFFFF; bus.rt_i = 32'hFFFF;
    @(posedge clock); #1 bus.start_i = 1'b0;
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_busy", bus.busy_o, 0);
    chk("abort_hi", bus.hi_o, 0);
    chk("abort_lo", bus.lo_o, 0);
    repeat (40) @(negedge clock);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
